// File: rtl/aftab_irq_pending_ctrl.sv
// Edge-triggered interrupt pending register with a request/service handshake FSM.
// Define AFTAB_IRQ_SYNC_EN to insert a two-flop synchronizer ahead of edge detection.
module aftab_irq_pending_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int CAUSE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               global_ie,
  input  logic               clr_all,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic               irq_req,
  output logic [CAUSE_W-1:0] irq_cause,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [NUM_IRQ-1:0] w_samp_in;
  logic [NUM_IRQ-1:0] r_samp;
  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_active;
  logic [NUM_IRQ-1:0] w_pending_next;
  logic [NUM_IRQ-1:0] r_pending;
  logic               r_req;
  logic               w_req_next;
  logic [CAUSE_W-1:0] r_cause;
  logic [CAUSE_W-1:0] w_cause_next;
  logic [CAUSE_W-1:0] w_lowest;
  logic               w_any_active;
  logic               w_cause_en;
  logic               w_ack_take;

`ifdef AFTAB_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_samp_in = r_sync2;
`else
  assign w_samp_in = irq_in;
`endif

  // r_samp/r_prev hold two consecutive samples; a 0->1 pair is one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp <= '0;
      r_prev <= '0;
    end else begin
      r_samp <= w_samp_in;
      r_prev <= r_samp;
    end
  end

  assign w_rise       = r_samp & ~r_prev;
  assign w_active     = r_pending & irq_en;
  assign w_any_active = |w_active;
  assign w_cause_en   = irq_en[r_cause];
  assign w_ack_take   = (r_state == ST_REQ) && irq_ack;

  // A new edge beats the acknowledge clear of the same bit.
  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pend
      logic w_clr;
      assign w_clr = w_ack_take && (r_cause == CAUSE_W'(gi));
      assign w_pending_next[gi] = clr_all ? 1'b0
                                : (w_rise[gi] | (r_pending[gi] & ~w_clr));
    end
  endgenerate

  always_comb begin
    w_lowest = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) w_lowest = CAUSE_W'(i);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cause_next = r_cause;
    case (r_state)
      ST_IDLE: begin
        if (global_ie && w_any_active) begin
          w_state_next = ST_REQ;
          w_cause_next = w_lowest;
        end
      end
      ST_REQ: begin
        if (irq_ack)                        w_state_next = ST_SERVICE;
        else if (!global_ie || !w_cause_en) w_state_next = ST_IDLE;
      end
      ST_SERVICE: begin
        if (irq_done) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (clr_all) begin
      w_state_next = ST_IDLE;
      w_cause_next = '0;
    end
    w_req_next = (w_state_next == ST_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_cause   <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_next;
      r_req     <= w_req_next;
      r_cause   <= w_cause_next;
      r_pending <= w_pending_next;
    end
  end

  assign irq_req   = r_req;
  assign irq_cause = r_cause;
  assign pending   = r_pending;

endmodule

// File: tb/tb_aftab_irq_pending_ctrl.sv
// Bench for aftab_irq_pending_ctrl: directed scenarios plus random traffic vs. a reference model.
module tb_aftab_irq_pending_ctrl;

  localparam int N = 8;
`ifdef AFTAB_IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int PH_IDLE = 0, PH_REQ = 1, PH_SERVICE = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_in, irq_en;
  logic         global_ie, clr_all, irq_ack, irq_done;
  logic         irq_req;
  logic [2:0]   irq_cause;
  logic [N-1:0] pending;

  int total = 0;
  int bad   = 0;

  aftab_irq_pending_ctrl #(.NUM_IRQ(N), .CAUSE_W(3)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .irq_en(irq_en),
    .global_ie(global_ie), .clr_all(clr_all), .irq_ack(irq_ack),
    .irq_done(irq_done), .irq_req(irq_req), .irq_cause(irq_cause),
    .pending(pending)
  );

  always #5 clk = ~clk;

  // Reference model: history of raw samples, pending vector and phase of the handshake.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_pend, m_rise, m_clr, m_act;
  logic [2:0]   m_cause;
  int           m_phase;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = '0; m_cause = '0; m_phase = PH_IDLE;
      hist.delete();
      for (int k = 0; k < LAT + 3; k++) hist.push_back('0);
    end else begin
      hist.push_front(irq_in);
      m_rise = hist[LAT+1] & ~hist[LAT+2];
      void'(hist.pop_back());
      m_clr = '0;
      m_act = m_pend & irq_en;
      if (clr_all) begin
        m_pend = '0; m_cause = '0; m_phase = PH_IDLE;
      end else begin
        if (m_phase == PH_IDLE) begin
          if (global_ie && m_act != 0) begin
            m_phase = PH_REQ;
            for (int k = N - 1; k >= 0; k--) if (m_act[k]) m_cause = 3'(k);
          end
        end else if (m_phase == PH_REQ) begin
          if (irq_ack) begin
            m_clr[m_cause] = 1'b1;
            m_phase = PH_SERVICE;
          end else if (!global_ie || !irq_en[m_cause]) begin
            m_phase = PH_IDLE;
          end
        end else if (irq_done) begin
          m_phase = PH_IDLE;
        end
        m_pend = (m_pend & ~m_clr) | m_rise;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse(input logic [N-1:0] mask);
    irq_in = mask;
    tick();
    irq_in = '0;
  endtask

  task automatic test_reset();
    tick();
    if (irq_req !== 1'b0) begin $display("FAIL reset_req got=%b want=0", irq_req); bad++; end
    total++;
    if (irq_cause !== 3'd0) begin $display("FAIL reset_cause got=%0d want=0", irq_cause); bad++; end
    total++;
    if (pending !== 8'h00) begin $display("FAIL reset_pending got=%h want=00", pending); bad++; end
    total++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_pulse();
    pulse(8'h20);
    repeat (LAT) tick();
    if (pending !== 8'h00) begin $display("FAIL pulse_early got=%h want=00", pending); bad++; end
    total++;
    tick();
    if (pending !== 8'h20 || irq_req !== 1'b0) begin
      $display("FAIL pulse_pending got=%h/%b want=20/0", pending, irq_req); bad++;
    end
    total++;
    tick();
    if (irq_req !== 1'b1 || irq_cause !== 3'd5) begin
      $display("FAIL pulse_req got=%b/%0d want=1/5", irq_req, irq_cause); bad++;
    end
    total++;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    if (pending !== 8'h00 || irq_req !== 1'b0) begin
      $display("FAIL pulse_ack got=%h/%b want=00/0", pending, irq_req); bad++;
    end
    total++;
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    $display("single pulse done: pending=%h req=%b", pending, irq_req);
  endtask

  task automatic test_priority();
    pulse(8'h44);
    repeat (LAT + 2) tick();
    if (irq_req !== 1'b1 || irq_cause !== 3'd2) begin
      $display("FAIL prio_first got=%b/%0d want=1/2", irq_req, irq_cause); bad++;
    end
    total++;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    if (pending !== 8'h40) begin $display("FAIL prio_after_ack got=%h want=40", pending); bad++; end
    total++;
    tick();
    if (irq_req !== 1'b0) begin $display("FAIL prio_nesting got=%b want=0", irq_req); bad++; end
    total++;
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    tick();
    if (irq_req !== 1'b1 || irq_cause !== 3'd6) begin
      $display("FAIL prio_second got=%b/%0d want=1/6", irq_req, irq_cause); bad++;
    end
    total++;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    $display("priority done: pending=%h", pending);
  endtask

  task automatic test_withdrawal();
    pulse(8'h08);
    repeat (LAT + 2) tick();
    if (irq_req !== 1'b1 || irq_cause !== 3'd3) begin
      $display("FAIL wd_req got=%b/%0d want=1/3", irq_req, irq_cause); bad++;
    end
    total++;
    global_ie = 1'b0; tick();
    if (irq_req !== 1'b0 || pending !== 8'h08) begin
      $display("FAIL wd_drop got=%b/%h want=0/08", irq_req, pending); bad++;
    end
    total++;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    if (pending !== 8'h08) begin $display("FAIL wd_stray_ack got=%h want=08", pending); bad++; end
    total++;
    global_ie = 1'b1; tick();
    if (irq_req !== 1'b1 || irq_cause !== 3'd3) begin
      $display("FAIL wd_resume got=%b/%0d want=1/3", irq_req, irq_cause); bad++;
    end
    total++;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    $display("withdrawal done: pending=%h", pending);
  endtask

  task automatic test_ack_collision();
    pulse(8'h10);
    repeat (LAT + 2) tick();
    if (irq_req !== 1'b1 || irq_cause !== 3'd4) begin
      $display("FAIL col_req got=%b/%0d want=1/4", irq_req, irq_cause); bad++;
    end
    total++;
    pulse(8'h10);
    repeat (LAT) tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    if (pending !== 8'h10 || irq_req !== 1'b0) begin
      $display("FAIL col_set_wins got=%h/%b want=10/0", pending, irq_req); bad++;
    end
    total++;
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    tick();
    if (irq_req !== 1'b1 || irq_cause !== 3'd4) begin
      $display("FAIL col_rereq got=%b/%0d want=1/4", irq_req, irq_cause); bad++;
    end
    total++;
    pulse(8'h10);
    repeat (LAT) tick();
    irq_ack = 1'b1; clr_all = 1'b1; tick(); irq_ack = 1'b0; clr_all = 1'b0;
    if (pending !== 8'h00 || irq_req !== 1'b0 || irq_cause !== 3'd0) begin
      $display("FAIL col_clr got=%h/%b/%0d want=00/0/0", pending, irq_req, irq_cause); bad++;
    end
    total++;
    pulse(8'h01);
    repeat (LAT + 2) tick();
    if (irq_req !== 1'b1 || irq_cause !== 3'd0) begin
      $display("FAIL col_idle_after_clr got=%b/%0d want=1/0", irq_req, irq_cause); bad++;
    end
    total++;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    $display("ack collision done: pending=%h", pending);
  endtask

  task automatic test_level_and_reset();
    int reqs = 0;
    logic was = 1'b0;
    irq_in = 8'h02;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (irq_req && !was) reqs++;
      was = irq_req;
      irq_ack = irq_req;
      irq_done = !irq_req;
    end
    irq_in = '0; irq_ack = 1'b0; irq_done = 1'b0;
    if (reqs != 1) begin $display("FAIL level_once got=%0d want=1", reqs); bad++; end
    total++;
    repeat (3) tick();
    pulse(8'h80);
    repeat (LAT + 2) tick();
    if (irq_req !== 1'b1 || irq_cause !== 3'd7) begin
      $display("FAIL rst_pre got=%b/%0d want=1/7", irq_req, irq_cause); bad++;
    end
    total++;
    rst = 1'b1; irq_in = 8'h02;
    #1;
    if (irq_req !== 1'b0 || pending !== 8'h00 || irq_cause !== 3'd0) begin
      $display("FAIL rst_async got=%b/%h/%0d want=0/00/0", irq_req, pending, irq_cause); bad++;
    end
    total++;
    tick();
    rst = 1'b0;
    tick();
    repeat (LAT) tick();
    if (pending !== 8'h00) begin $display("FAIL release_early got=%h want=00", pending); bad++; end
    total++;
    tick();
    if (pending !== 8'h02) begin $display("FAIL release_edge got=%h want=02", pending); bad++; end
    total++;
    tick();
    if (irq_req !== 1'b1 || irq_cause !== 3'd1) begin
      $display("FAIL release_req got=%b/%0d want=1/1", irq_req, irq_cause); bad++;
    end
    total++;
    irq_in = '0;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    $display("level and reset done: pending=%h", pending);
  endtask

  task automatic test_random();
    logic [N-1:0] one = 1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) irq_in = irq_in ^ (one << $urandom_range(0, N - 1));
      irq_en    = ($urandom_range(0, 5) == 0) ? N'($urandom) : '1;
      global_ie = ($urandom_range(0, 7) != 0);
      irq_ack   = ($urandom_range(0, 2) == 0);
      irq_done  = ($urandom_range(0, 3) == 0);
      clr_all   = ($urandom_range(0, 39) == 0);
      tick();
      if (irq_req !== (m_phase == PH_REQ)) begin
        $display("FAIL rnd_req cyc=%0d got=%b want=%b", c, irq_req, (m_phase == PH_REQ)); bad++;
      end
      total++;
      if (irq_cause !== m_cause) begin
        $display("FAIL rnd_cause cyc=%0d got=%0d want=%0d", c, irq_cause, m_cause); bad++;
      end
      total++;
      if (pending !== m_pend) begin
        $display("FAIL rnd_pending cyc=%0d got=%h want=%h", c, pending, m_pend); bad++;
      end
      total++;
    end
    irq_in = '0; irq_ack = 1'b0; irq_done = 1'b0; clr_all = 1'b0;
    irq_en = '1; global_ie = 1'b1;
    $display("random done: pending=%h req=%b", pending, irq_req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    irq_in = '0; irq_en = 8'hFF; global_ie = 1'b1;
    clr_all = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
    test_reset();
    test_single_pulse();
    test_priority();
    test_withdrawal();
    test_ack_collision();
    test_level_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
